// File: rtl/binary_conv3x3_pkg.sv
// Shared constants, FSM encoding and popcount helper for the 3x3 binary convolution.
package binary_conv3x3_pkg;

    localparam int IMG_W = 30;   // pixels per row
    localparam int IMG_H = 30;   // rows per frame
    localparam int CW    = 5;    // column counter width
    localparam int RW    = 5;    // row counter width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Number of set bits in a 3x3 window, 0..9.
    function automatic logic [3:0] popcount9(input logic [8:0] bits);
        logic [3:0] sum;
        sum = '0;
        for (int i = 0; i < 9; i++) begin
            sum = sum + {3'b000, bits[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/binary_conv3x3_if.sv
// Pixel stream, frame configuration and status signals of the 3x3 binary convolution.
interface binary_conv3x3_if;

    logic       iCLR;
    logic       iEN;
    logic       iDATA;
    logic [8:0] iKERNEL;
    logic [3:0] iTHRESH;
    logic       oEN;
    logic       oDATA;
    logic       oBUSY;
    logic       oDONE;

    modport master (
        output iCLR, iEN, iDATA, iKERNEL, iTHRESH,
        input  oEN, oDATA, oBUSY, oDONE
    );

    modport slave (
        input  iCLR, iEN, iDATA, iKERNEL, iTHRESH,
        output oEN, oDATA, oBUSY, oDONE
    );

endinterface

// File: rtl/binary_conv3x3_line_buf.sv
// One raster line of delay: oDATA is the pixel shifted in W steps earlier.
module binary_conv3x3_line_buf
    import binary_conv3x3_pkg::*;
#(
    parameter int W = IMG_W
) (
    input  logic iCLK,
    input  logic iRSTn,
    input  logic iCLR,
    input  logic iEN,
    input  logic iDATA,
    output logic oDATA
);

    logic [W-1:0] shiftReg;

    // Shift one pixel per step; frame abort empties the line.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            shiftReg <= '0;
        end else if (iCLR) begin
            shiftReg <= '0;
        end else if (iEN) begin
            shiftReg <= {shiftReg[W-2:0], iDATA};
        end
    end

    assign oDATA = shiftReg[W-1];

endmodule

// File: rtl/binary_conv3x3.sv
// Streaming 3x3 binary convolution with zero padding: oDATA = popcount(window & kernel) >= threshold.
module binary_conv3x3
    import binary_conv3x3_pkg::*;
(
    input  logic            iCLK,
    input  logic            iRSTn,
    binary_conv3x3_if.slave bus
);

    state_t        stateReg, stateNext;
    logic [CW-1:0] inColReg, outColReg, flushCntReg;
    logic [RW-1:0] inRowReg, outRowReg;
    logic [2:0]    tapCReg, tapLReg;      // columns c and c-1; bit2=top, bit0=bottom
    logic          oEnReg, oDataReg, oDoneReg;

    logic          flushing, accept, step, pixel, emit, lastOut, fire;
    logic          topOk, botOk, leftOk, rightOk;
    logic [1:0]    lbIn, lbOut;
    logic [2:0]    colR;
    logic [8:0]    window, padMask;

    assign flushing = (stateReg == FLUSH);
    assign accept   = bus.iEN && !flushing && !bus.iCLR;
    assign step     = accept || (flushing && !bus.iCLR);
    // During flush the raster is extended with zero pixels.
    assign pixel    = flushing ? 1'b0 : bus.iDATA;

    // Line 0 delays the incoming pixel by one row, line 1 by two rows.
    assign lbIn[0] = pixel;
    assign lbIn[1] = lbOut[0];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            binary_conv3x3_line_buf #(.W(IMG_W)) uLine (
                .iCLK  (iCLK),
                .iRSTn (iRSTn),
                .iCLR  (bus.iCLR),
                .iEN   (step),
                .iDATA (lbIn[gi]),
                .oDATA (lbOut[gi])
            );
        end
    endgenerate

    // Column c+1 of the window is formed combinationally from the line-buffer tails.
    assign colR   = {lbOut[1], lbOut[0], pixel};
    assign window = {tapLReg[2], tapCReg[2], colR[2],
                     tapLReg[1], tapCReg[1], colR[1],
                     tapLReg[0], tapCReg[0], colR[0]};

    // Padding follows the output position so neighbours never wrap across rows or frames.
    assign topOk   = (outRowReg != '0);
    assign botOk   = (outRowReg != RW'(IMG_H - 1));
    assign leftOk  = (outColReg != '0);
    assign rightOk = (outColReg != CW'(IMG_W - 1));
    assign padMask = {topOk & leftOk, topOk, topOk & rightOk,
                      leftOk,         1'b1,  rightOk,
                      botOk & leftOk, botOk, botOk & rightOk};

    assign fire = (popcount9(window & padMask & bus.iKERNEL) >= bus.iTHRESH);

    // Next-state and per-step output decisions.
    always_comb begin
        stateNext = stateReg;
        emit      = 1'b0;
        lastOut   = 1'b0;
        unique case (stateReg)
            IDLE: begin
                if (accept) stateNext = FILL;
            end
            FILL: begin
                // Pixel IMG_W is the last one without an output.
                if (accept && inRowReg == RW'(1) && inColReg == '0) stateNext = RUN;
            end
            RUN: begin
                if (accept) begin
                    emit = 1'b1;
                    if (inRowReg == RW'(IMG_H - 1) && inColReg == CW'(IMG_W - 1)) stateNext = FLUSH;
                end
            end
            FLUSH: begin
                emit = 1'b1;
                if (flushCntReg == CW'(IMG_W)) begin
                    lastOut   = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // FSM state register; frame abort returns to IDLE.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            stateReg <= IDLE;
        end else if (bus.iCLR) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Input, output and flush position counters.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            inColReg    <= '0;
            inRowReg    <= '0;
            outColReg   <= '0;
            outRowReg   <= '0;
            flushCntReg <= '0;
        end else if (bus.iCLR) begin
            inColReg    <= '0;
            inRowReg    <= '0;
            outColReg   <= '0;
            outRowReg   <= '0;
            flushCntReg <= '0;
        end else begin
            if (accept) begin
                if (inColReg == CW'(IMG_W - 1)) begin
                    inColReg <= '0;
                    inRowReg <= (inRowReg == RW'(IMG_H - 1)) ? '0 : inRowReg + 1'b1;
                end else begin
                    inColReg <= inColReg + 1'b1;
                end
            end
            if (emit) begin
                if (outColReg == CW'(IMG_W - 1)) begin
                    outColReg <= '0;
                    outRowReg <= (outRowReg == RW'(IMG_H - 1)) ? '0 : outRowReg + 1'b1;
                end else begin
                    outColReg <= outColReg + 1'b1;
                end
            end
            if (flushing) begin
                flushCntReg <= (flushCntReg == CW'(IMG_W)) ? '0 : flushCntReg + 1'b1;
            end
        end
    end

    // Tap register: keep the two previous window columns.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            tapCReg <= '0;
            tapLReg <= '0;
        end else if (bus.iCLR) begin
            tapCReg <= '0;
            tapLReg <= '0;
        end else if (step) begin
            tapLReg <= tapCReg;
            tapCReg <= colR;
        end
    end

    // Registered output strobe, data and end-of-frame pulse.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            oEnReg   <= 1'b0;
            oDataReg <= 1'b0;
            oDoneReg <= 1'b0;
        end else if (bus.iCLR) begin
            oEnReg   <= 1'b0;
            oDataReg <= 1'b0;
            oDoneReg <= 1'b0;
        end else begin
            oEnReg   <= emit;
            oDataReg <= emit & fire;
            oDoneReg <= lastOut;
        end
    end

    assign bus.oEN   = oEnReg;
    assign bus.oDATA = oDataReg;
    assign bus.oDONE = oDoneReg;
    assign bus.oBUSY = flushing;

endmodule
